// File: rtl/top.sv
// Single-cycle MIPS-subset core with private instruction RAM.
// Optional macro TOP_SHIFT_EN enables sll/srl/sra; otherwise those encodings are NOPs.

// Register file: 32 x 32-bit, $0 hard-wired to zero.
// Latency: reads combinational, write lands on the rising edge.
// Backpressure: none, one write accepted every cycle.
module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr,
    output logic [31:0] rs_dat,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rt_dat,
    input  logic        wr_vld,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_dat
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_vld && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_dat;
        end
    end

    assign rs_dat = (rs_addr == 5'd0) ? '0 : regs[rs_addr];
    assign rt_dat = (rt_addr == 5'd0) ? '0 : regs[rt_addr];
endmodule

// Instruction memory, word addressed, contents survive reset.
// Latency: combinational read, write on the rising edge.
// Backpressure: none.
module mips_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_dat
);
    logic [31:0] memory [0:WORDS-1];

    // Loader port; programs are normally preloaded from a hex image.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            memory[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = memory[rd_addr];
endmodule

// Core: fetch, decode, execute and writeback in one clock.
// Latency: one instruction retired per rising edge.
// Backpressure: none, the core never stalls.
module mips_core #(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          AW        = $clog2(RAM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   instr_dat,
    output logic [AW-1:0] fetch_addr
);
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
`ifdef TOP_SHIFT_EN
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
`endif

    logic [31:0]   pc;
    logic [AW-1:0] word_next;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [31:0]   imm_zx;
    logic [31:0]   rs_dat;
    logic [31:0]   rt_dat;
    logic          wr_vld;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_dat;

    assign {opcode, rs, rt, rd, shamt, funct} = instr_dat;
    assign imm_zx     = {16'h0000, instr_dat[15:0]};
    assign fetch_addr = pc[AW+1:2];
    assign word_next  = fetch_addr + {{(AW-1){1'b0}}, 1'b1};

    // Only the word index advances, so the pc itself wraps with the memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= {pc[31:AW+2], word_next, pc[1:0]};
        end
    end

    always_comb begin
        wr_vld  = 1'b0;
        wr_addr = rd;
        wr_dat  = '0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_AND: begin wr_vld = 1'b1; wr_dat = rs_dat & rt_dat;    end
                    FN_OR:  begin wr_vld = 1'b1; wr_dat = rs_dat | rt_dat;    end
                    FN_XOR: begin wr_vld = 1'b1; wr_dat = rs_dat ^ rt_dat;    end
                    FN_NOR: begin wr_vld = 1'b1; wr_dat = ~(rs_dat | rt_dat); end
`ifdef TOP_SHIFT_EN
                    FN_SLL: begin wr_vld = 1'b1; wr_dat = rt_dat << shamt;    end
                    FN_SRL: begin wr_vld = 1'b1; wr_dat = rt_dat >> shamt;    end
                    FN_SRA: begin
                        wr_vld = 1'b1;
                        wr_dat = $unsigned($signed(rt_dat) >>> shamt);
                    end
`endif
                    default: ;
                endcase
            end
            OP_ANDI: begin wr_vld = 1'b1; wr_addr = rt; wr_dat = rs_dat & imm_zx; end
            OP_ORI:  begin wr_vld = 1'b1; wr_addr = rt; wr_dat = rs_dat | imm_zx; end
            OP_XORI: begin wr_vld = 1'b1; wr_addr = rt; wr_dat = rs_dat ^ imm_zx; end
            OP_LUI:  begin wr_vld = 1'b1; wr_addr = rt; wr_dat = {instr_dat[15:0], 16'h0000}; end
            default: ;
        endcase
    end

`ifndef TOP_SHIFT_EN
    logic unused_shamt;
    assign unused_shamt = ^shamt;
`endif

    mips_regfile regfile (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs),
        .rs_dat  (rs_dat),
        .rt_addr (rt),
        .rt_dat  (rt_dat),
        .wr_vld  (wr_vld),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat)
    );
endmodule

// Top: core plus instruction RAM, no external data ports.
// Latency: one instruction per clock from the first edge after reset release.
// Backpressure: none.
module top #(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [AW-1:0] fetch_addr;
    logic [31:0]   instr_dat;

    mips_core #(
        .RAM_WORDS (RAM_WORDS),
        .RESET_PC  (RESET_PC)
    ) openmips (
        .clk        (clk),
        .rst        (rst),
        .instr_dat  (instr_dat),
        .fetch_addr (fetch_addr)
    );

    mips_ram #(
        .WORDS (RAM_WORDS)
    ) ram (
        .clk     (clk),
        .wr_vld  (1'b0),
        .wr_addr ('0),
        .wr_dat  ('0),
        .rd_addr (fetch_addr),
        .rd_dat  (instr_dat)
    );
endmodule

// File: tb/tb_top.sv
// Bench for top: directed programs plus random programs checked against an ISA-level model.
module tb_top;
    localparam int WORDS = 1024;

    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    logic [31:0] prog [$];
    logic [31:0] m_mem  [WORDS];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    top #(.RAM_WORDS(WORDS), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        int r1;
        int r2;
        int r3;
        k  = $urandom_range(0, 12);
        r1 = $urandom_range(0, 7);
        r2 = $urandom_range(0, 7);
        r3 = $urandom_range(0, 7);
        case (k)
            0:  return enc_r(r1, r2, r3, 0, 'h24);
            1:  return enc_r(r1, r2, r3, 0, 'h25);
            2:  return enc_r(r1, r2, r3, 0, 'h26);
            3:  return enc_r(r1, r2, r3, 0, 'h27);
            4:  return enc_r(0, r2, r3, $urandom_range(0, 31), 'h00);
            5:  return enc_r(0, r2, r3, $urandom_range(0, 31), 'h02);
            6:  return enc_r(0, r2, r3, $urandom_range(0, 31), 'h03);
            7:  return enc_i('h0C, r1, r2, $urandom);
            8:  return enc_i('h0D, r1, r2, $urandom);
            9:  return enc_i('h0E, r1, r2, $urandom);
            10: return enc_i('h0F, 0, r2, $urandom);
            11: return $urandom;
            default: return 32'h0;
        endcase
    endfunction

    // Architectural model: one instruction per call, straight from the ISA rules.
    task automatic model_step();
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] res;
        logic [4:0]  dst;
        logic        wr;
        ins = m_mem[m_pc[11:2]];
        a   = m_regs[ins[25:21]];
        b   = m_regs[ins[20:16]];
        imm = {16'h0000, ins[15:0]};
        wr  = 1'b0;
        dst = ins[20:16];
        res = '0;
        if (ins[31:26] == 6'h00) begin
            dst = ins[15:11];
            wr  = 1'b1;
            case (ins[5:0])
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h26: res = a ^ b;
                6'h27: res = ~(a | b);
`ifdef TOP_SHIFT_EN
                6'h00: res = b << ins[10:6];
                6'h02: res = b >> ins[10:6];
                6'h03: res = $unsigned($signed(b) >>> ins[10:6]);
`endif
                default: wr = 1'b0;
            endcase
        end else begin
            wr = 1'b1;
            case (ins[31:26])
                6'h0C: res = a & imm;
                6'h0D: res = a | imm;
                6'h0E: res = a ^ imm;
                6'h0F: res = {ins[15:0], 16'h0000};
                default: wr = 1'b0;
            endcase
        end
        if (wr && dst != 5'd0) m_regs[dst] = res;
        m_pc = (m_pc + 32'd4) % 32'(WORDS * 4);
    endtask

    task automatic model_reset();
        m_pc = '0;
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
    endtask

    task automatic compare_state(input string tag);
        check({tag, "_pc"}, dut.openmips.pc, m_pc);
        for (int r = 0; r < 32; r++) begin
            logic [4:0] ri;
            ri = r[4:0];
            check($sformatf("%s_r%0d", tag, r), dut.openmips.regfile.regs[ri], m_regs[ri]);
        end
    endtask

    // Loads memory while reset is held, then checks state through the hold.
    task automatic start_prog(input int hold);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < WORDS; i++) begin
            logic [9:0]  a;
            logic [31:0] w;
            a = i[9:0];
            w = (i < prog.size()) ? prog[i] : 32'h0;
            dut.ram.memory[a] <= w;
            m_mem[a] = w;
        end
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            compare_state("rst_hold");
        end
        rst = 1'b1;
    endtask

    task automatic run(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_state(tag);
        end
    endtask

    task automatic set_logic_prog();
        prog.delete();
        prog.push_back(enc_i('h0F, 0, 1, 'h0101));
        prog.push_back(enc_i('h0D, 1, 1, 'h0101));
        prog.push_back(enc_i('h0D, 1, 2, 'h1100));
        prog.push_back(enc_r(1, 2, 1, 0, 'h25));
        prog.push_back(enc_i('h0C, 1, 3, 'h00FE));
        prog.push_back(enc_r(3, 1, 1, 0, 'h24));
        prog.push_back(enc_i('h0E, 1, 4, 'hFF00));
        prog.push_back(enc_r(4, 1, 1, 0, 'h26));
        prog.push_back(enc_r(4, 1, 1, 0, 'h27));
    endtask

    task automatic check_logic_final(input string tag);
        check({tag, "_r1"}, dut.openmips.regfile.regs[1], 32'hFFFF00FF);
        check({tag, "_r2"}, dut.openmips.regfile.regs[2], 32'h01011101);
        check({tag, "_r3"}, dut.openmips.regfile.regs[3], 32'h00000000);
        check({tag, "_r4"}, dut.openmips.regfile.regs[4], 32'h0000FF00);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;

        // Logic program with a long reset hold.
        set_logic_prog();
        start_prog(10);
        run(1, "logic");
        check("first_wb_r1", dut.openmips.regfile.regs[1], 32'h01010000);
        run(3, "logic");
        check("after_or_r1", dut.openmips.regfile.regs[1], 32'h01011101);
        run(5, "logic");
        check_logic_final("logic_final");

        // Reset mid-program, then re-execute.
        start_prog(2);
        run(4, "pre_abort");
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_state("async_rst");
        @(negedge clk);
        compare_state("rst_over_edge");
        rst = 1'b1;
        run(9, "rerun");
        check_logic_final("rerun_final");

        // Writes to $0 are discarded.
        prog.delete();
        prog.push_back(enc_i('h0D, 0, 5, 'h1234));
        prog.push_back(enc_i('h0D, 0, 0, 'hFFFF));
        prog.push_back(enc_r(0, 0, 5, 0, 'h25));
        start_prog(1);
        run(1, "zero_reg");
        check("r5_seed", dut.openmips.regfile.regs[5], 32'h00001234);
        run(2, "zero_reg");
        check("r0_final", dut.openmips.regfile.regs[0], 32'h0);
        check("r5_final", dut.openmips.regfile.regs[5], 32'h0);

        // Shifts.
        prog.delete();
        prog.push_back(enc_i('h0D, 0, 1, 'h8000));
        prog.push_back(enc_r(0, 1, 2, 16, 'h00));
        prog.push_back(enc_r(0, 2, 3, 4, 'h03));
        prog.push_back(enc_r(0, 2, 4, 4, 'h02));
        start_prog(1);
        run(4, "shift");
        check("shift_r1", dut.openmips.regfile.regs[1], 32'h00008000);
`ifdef TOP_SHIFT_EN
        check("sll_r2", dut.openmips.regfile.regs[2], 32'h80000000);
        check("sra_r3", dut.openmips.regfile.regs[3], 32'hF8000000);
        check("srl_r4", dut.openmips.regfile.regs[4], 32'h08000000);
`else
        check("sll_nop_r2", dut.openmips.regfile.regs[2], 32'h0);
        check("sra_nop_r3", dut.openmips.regfile.regs[3], 32'h0);
        check("srl_nop_r4", dut.openmips.regfile.regs[4], 32'h0);
`endif

        // All-zero memory: pc wraps, registers untouched.
        prog.delete();
        start_prog(1);
        run(WORDS - 1, "zeros");
        check("pc_before_wrap", dut.openmips.pc, 32'(4 * (WORDS - 1)));
        run(1, "zeros");
        check("pc_wrapped", dut.openmips.pc, 32'h0);
        run(3, "zeros");

        // Random programs.
        for (int p = 0; p < 4; p++) begin
            prog.delete();
            for (int i = 0; i < 48; i++) prog.push_back(rand_instr());
            start_prog(1);
            run(60, $sformatf("rand%0d", p));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 RAM_WORDS, 1024, depth of instruction memory in 32-bit words (power of two).
REQ-002 RESET_PC, 32'h00000000, program counter value loaded during reset.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 No other ports; the block is a self-contained processor plus instruction memory, observed through internal state only.

Function
REQ-006 Hierarchy SHALL be: core instance "openmips" containing register-file instance "regfile" with array regs[0:31] (32-bit); memory instance "ram" with array memory[0:RAM_WORDS-1] (32-bit words), loadable by $readmemh, never cleared by reset.
REQ-007 Core SHALL be single-cycle, non-pipelined: one instruction fetched, decoded, executed and written back per clk cycle.
REQ-008 Fetch: instruction = memory[pc[log2(RAM_WORDS)+1:2]], combinational read; pc advances by 4 every cycle out of reset; address wraps modulo RAM_WORDS words.
REQ-009 Supported R-type (opcode 0): and, or, xor, nor (funct 0x24, 0x25, 0x26, 0x27), rd = rs op rt.
REQ-010 Supported shifts (opcode 0): sll, srl, sra (funct 0x00, 0x02, 0x03), rd = rt shifted by shamt; sra sign-fills.
REQ-011 Supported I-type: andi 0x0C, ori 0x0D, xori 0x0E with 16-bit immediate zero-extended, rt = rs op imm.
REQ-012 lui (opcode 0x0F): rt = {imm, 16'h0000}.
REQ-013 Any other encoding, including all-zero word, SHALL execute as NOP (no register write, pc += 4).
REQ-014 regs[0] SHALL always read 0; writes to register 0 are discarded.
REQ-015 Operands read combinationally; destination written at rising edge ending the cycle, so the next instruction sees the new value (no hazards exist).
REQ-016 Register file: two asynchronous read ports, one synchronous write port.

Reset
REQ-017 While rst low: pc = RESET_PC, regs[0..31] = 0, no writes occur; effect immediate (asynchronous).
REQ-018 First instruction (at RESET_PC) retires on first rising clk edge after rst goes high.
REQ-019 Reset asserted mid-program SHALL abort the current instruction without its writeback and restart from RESET_PC.

Configuration
REQ-020 Macro TOP_SHIFT_EN: defined -> sll/srl/sra executed per REQ-010; undefined -> those encodings are NOPs (sll $0,$0,0 remains NOP in both cases).

Verification
REQ-021 Logic program at word 0: lui $1,0x0101; ori $1,$1,0x0101; ori $2,$1,0x1100; or $1,$1,$2; andi $3,$1,0x00fe; and $1,$3,$1; xori $4,$1,0xff00; xor $1,$4,$1; nor $1,$4,$1 -> $1 sequence 01010000, 01010101, 01011101, 00000000, 0000FF00, FFFF00FF; final $2=01011101, $3=00000000, $4=0000FF00.
REQ-022 Reset hold: rst low for 10 cycles with program loaded -> pc=0, all regs 0, no change; first write visible after first edge following release.
REQ-023 ori $0,$0,0xFFFF then or $5,$0,$0 -> regs[0]=0, regs[5]=0.
REQ-024 With TOP_SHIFT_EN: ori $1,$0,0x8000; sll $2,$1,16; sra $3,$2,4; srl $4,$2,4 -> $2=80000000, $3=F8000000, $4=08000000; without macro $2..$4 stay 0.
REQ-025 Reset pulse low after 4th instruction of REQ-021 -> regs cleared, pc=0, program re-executes giving identical final values.
REQ-026 Memory of all zeros run past RAM_WORDS instructions -> pc wraps to 0, no register changes.
